// File: rtl/sm3_ctrl.sv
// Block sequencer for an SM3 compression core: accepts padded 512-bit blocks,
// chains the 256-bit state across blocks and strobes the final digest.
// Optional watchdog on the core handshake is enabled by defining SM3_CTRL_WDT_EN.
module sm3_ctrl (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [511:0] i_data,
  input  logic         i_first,
  input  logic         i_last,
  output logic         o_core_start,
  output logic [511:0] o_core_data,
  output logic [255:0] o_core_vin,
  input  logic [255:0] i_core_vout,
  input  logic         i_core_done,
  output logic [255:0] o_hash,
  output logic         o_hash_valid,
  output logic         o_err
);

  localparam logic [255:0] IV = 256'h7380166f_4914b2b9_172442d7_da8a0600_a96f30bc_163138aa_e38dee4d_b0fb0e4e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t       state_reg, state_next;
  logic         accept, finish, timeout;
  logic         last_reg;
  logic [511:0] core_data_reg;
  logic [255:0] core_vin_reg;
  logic [255:0] chain_reg;
  logic [255:0] hash_reg;
  logic         hash_valid_reg;

`ifdef SM3_CTRL_WDT_EN
  logic [6:0] wdt_reg;
  logic       err_reg;

  // Timeout fires on the edge where the WAIT count would reach 80; a done on that edge wins.
  assign timeout = (state_reg == WAIT) && !i_core_done && (wdt_reg == 7'd79);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wdt_reg <= 7'd0;
      err_reg <= 1'b0;
    end else begin
      err_reg <= timeout;
      if (state_reg == START)
        wdt_reg <= 7'd0;
      else if (state_reg == WAIT)
        wdt_reg <= wdt_reg + 7'd1;
    end
  end

  assign o_err = err_reg;
`else
  assign timeout = 1'b0;
  assign o_err   = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst)
      state_reg <= IDLE;
    else
      state_reg <= state_next;
  end

  always_comb begin
    state_next   = state_reg;
    accept       = 1'b0;
    finish       = 1'b0;
    o_ready      = 1'b0;
    o_core_start = 1'b0;
    case (state_reg)
      IDLE: begin
        o_ready = 1'b1;
        if (i_valid) begin
          accept     = 1'b1;
          state_next = START;
        end
      end
      START: begin
        o_core_start = 1'b1;
        state_next   = WAIT;
      end
      WAIT: begin
        if (i_core_done) begin
          finish     = 1'b1;
          state_next = IDLE;
        end else if (timeout) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Core operands are captured at acceptance and held until the block retires.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      core_data_reg  <= '0;
      core_vin_reg   <= '0;
      chain_reg      <= '0;
      hash_reg       <= '0;
      hash_valid_reg <= 1'b0;
      last_reg       <= 1'b0;
    end else begin
      hash_valid_reg <= 1'b0;
      if (accept) begin
        core_data_reg <= i_data;
        core_vin_reg  <= i_first ? IV : chain_reg;
        last_reg      <= i_last;
      end
      if (finish) begin
        chain_reg <= i_core_vout;
        if (last_reg) begin
          hash_reg       <= i_core_vout;
          hash_valid_reg <= 1'b1;
        end
      end
    end
  end

  assign o_core_data  = core_data_reg;
  assign o_core_vin   = core_vin_reg;
  assign o_hash       = hash_reg;
  assign o_hash_valid = hash_valid_reg;

endmodule

// File: tb/tb_sm3_ctrl.sv
// Self-checking bench for sm3_ctrl with a behavioural SM3 compression core model.
// Watchdog scenarios run when SM3_CTRL_WDT_EN is defined.
module tb_sm3_ctrl;

  localparam logic [255:0] IV       = 256'h7380166f_4914b2b9_172442d7_da8a0600_a96f30bc_163138aa_e38dee4d_b0fb0e4e;
  localparam logic [255:0] ABC_HASH = 256'h66c7f0f4_62eeedd9_d1f2d46b_dc10e4e2_4167c487_5cf2f7a2_297da02b_8f4ba8e0;
  localparam logic [255:0] TWO_HASH = 256'hdebe9ff9_2275b8a1_38604889_c18e5a4d_6fdb70e5_387e5765_293dcba3_9c0c5732;

  logic         i_clk = 1'b0;
  logic         i_rst;
  logic         i_valid;
  logic         o_ready;
  logic [511:0] i_data;
  logic         i_first;
  logic         i_last;
  logic         o_core_start;
  logic [511:0] o_core_data;
  logic [255:0] o_core_vin;
  logic [255:0] i_core_vout;
  logic         i_core_done;
  logic [255:0] o_hash;
  logic         o_hash_valid;
  logic         o_err;

  sm3_ctrl dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_data(i_data), .i_first(i_first), .i_last(i_last),
    .o_core_start(o_core_start), .o_core_data(o_core_data), .o_core_vin(o_core_vin),
    .i_core_vout(i_core_vout), .i_core_done(i_core_done),
    .o_hash(o_hash), .o_hash_valid(o_hash_valid), .o_err(o_err)
  );

  always #5 i_clk = ~i_clk;

  // ---------------- SM3 compression reference ----------------
  function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
    int s;
    s = n % 32;
    if (s == 0) return x;
    return (x << s) | (x >> (32 - s));
  endfunction

  function automatic logic [31:0] p0(input logic [31:0] x);
    return x ^ rotl(x, 9) ^ rotl(x, 17);
  endfunction

  function automatic logic [31:0] p1(input logic [31:0] x);
    return x ^ rotl(x, 15) ^ rotl(x, 23);
  endfunction

  function automatic logic [255:0] sm3_cf(input logic [255:0] v, input logic [511:0] blk);
    logic [31:0] w [68];
    logic [31:0] wp [64];
    logic [31:0] a, b, c, d, e, f, g, h, ss1, ss2, tt1, tt2, tj, ffv, ggv;
    for (int j = 0; j < 16; j++) w[j] = blk[511 - 32*j -: 32];
    for (int j = 16; j < 68; j++)
      w[j] = p1(w[j-16] ^ w[j-9] ^ rotl(w[j-3], 15)) ^ rotl(w[j-13], 7) ^ w[j-6];
    for (int j = 0; j < 64; j++) wp[j] = w[j] ^ w[j+4];
    {a, b, c, d, e, f, g, h} = v;
    for (int j = 0; j < 64; j++) begin
      tj  = (j < 16) ? 32'h79cc4519 : 32'h7a879d8a;
      ss1 = rotl(rotl(a, 12) + e + rotl(tj, j), 7);
      ss2 = ss1 ^ rotl(a, 12);
      ffv = (j < 16) ? (a ^ b ^ c) : ((a & b) | (a & c) | (b & c));
      ggv = (j < 16) ? (e ^ f ^ g) : ((e & f) | (~e & g));
      tt1 = ffv + d + ss2 + wp[j];
      tt2 = ggv + h + ss1 + w[j];
      d = c; c = rotl(b, 9); b = a; a = tt1;
      h = g; g = rotl(f, 19); f = e; e = p0(tt2);
    end
    return {a, b, c, d, e, f, g, h} ^ v;
  endfunction

  // ---------------- core stub: fixed latency, result from held operands ----------------
  logic         core_done_stub = 1'b0;
  logic [255:0] core_vout_stub = '0;
  int           scnt = 0;
  int           stub_lat = 64;
  bit           stub_dead = 1'b0;
  logic         inj_done;
  logic [255:0] inj_vout;

  always @(posedge i_clk) begin
    core_done_stub <= 1'b0;
    if (i_rst) scnt <= 0;
    else if (o_core_start) scnt <= 1;
    else if (scnt != 0) begin
      if (scnt == stub_lat) begin
        scnt <= 0;
        if (!stub_dead) begin
          core_done_stub <= 1'b1;
          core_vout_stub <= sm3_cf(o_core_vin, o_core_data);
        end
      end else scnt <= scnt + 1;
    end
  end

  assign i_core_done = core_done_stub | inj_done;
  assign i_core_vout = inj_done ? inj_vout : core_vout_stub;

  // Event counters sampled mid-cycle
  int acc_cnt = 0, hv_cnt = 0, err_cnt = 0, done_cnt = 0;
  always @(negedge i_clk) begin
    if (i_valid && o_ready && !i_rst) acc_cnt <= acc_cnt + 1;
    if (o_hash_valid) hv_cnt <= hv_cnt + 1;
    if (o_err) err_cnt <= err_cnt + 1;
    if (core_done_stub) done_cnt <= done_cnt + 1;
  end

  // ---------------- checking infrastructure ----------------
  int n_assert = 0;
  int n_fail   = 0;
  logic [255:0] model_chain = '0;
  logic [255:0] model_hash  = '0;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  function automatic logic [511:0] rand_blk();
    logic [511:0] r;
    for (int k = 0; k < 16; k++) r[32*k +: 32] = $urandom;
    return r;
  endfunction

  task automatic send(input logic [511:0] d, input logic f, input logic l);
    int w;
    w = 0;
    while (!o_ready && w < 300) begin tick(); w++; end
    chk("ready_wait", o_ready, 1);
    i_valid = 1'b1; i_data = d; i_first = f; i_last = l;
    tick();
    i_valid = 1'b0;
  endtask

  // One block through the controller, checked against the chaining model.
  task automatic do_block(input logic [511:0] d, input logic f, input logic l);
    logic [255:0] ev;
    int n, hv_at, starts;
    ev = f ? IV : model_chain;
    send(d, f, l);
    chk("core_start", o_core_start, 1);
    chk("core_data", o_core_data, d);
    chk("core_vin", o_core_vin, ev);
    n = 0; hv_at = 0; starts = 0;
    while (n < 300) begin
      tick(); n++;
      if (o_core_start) starts++;
      if (o_hash_valid && hv_at == 0) hv_at = n;
      if (o_ready) break;
    end
    chk("ready_lat", n, stub_lat + 2);
    chk("single_start", starts, 0);
    model_chain = sm3_cf(ev, d);
    if (l) begin
      model_hash = model_chain;
      chk("hv_lat", hv_at, stub_lat + 2);
      chk("digest", o_hash, model_hash);
      tick();
      chk("hv_one_cycle", o_hash_valid, 0);
    end else begin
      chk("no_strobe", hv_at, 0);
      chk("hash_hold", o_hash, model_hash);
    end
    $display("block first=%0b last=%0b ready_after=%0d strobe_at=%0d hash=%h", f, l, n, hv_at, o_hash);
  endtask

  // ---------------- directed sequence ----------------
  logic [511:0] abc_blk, abcd_blk, pad_blk, rblk;
  int base_acc, base_hv, base_done, base_err, n;

  initial begin
    abc_blk  = '0; abc_blk[511:480] = 32'h61626380; abc_blk[31:0] = 32'h00000018;
    abcd_blk = {16{32'h61626364}};
    pad_blk  = '0; pad_blk[511:480] = 32'h80000000; pad_blk[31:0] = 32'h00000200;

    // Reset with a block offered and a spurious done: reset must win.
    i_rst = 1'b1; i_valid = 1'b1; i_data = abc_blk; i_first = 1'b1; i_last = 1'b1;
    inj_done = 1'b1; inj_vout = 256'hdead;
    repeat (3) tick();
    chk("rst_ready", o_ready, 1);
    chk("rst_start", o_core_start, 0);
    chk("rst_hv", o_hash_valid, 0);
    chk("rst_err", o_err, 0);
    chk("rst_hash", o_hash, 0);
    chk("rst_core_data", o_core_data, 0);
    chk("rst_core_vin", o_core_vin, 0);
    i_rst = 1'b0; i_valid = 1'b0; inj_done = 1'b0;
    tick();
    chk("rst_no_accept", acc_cnt, 0);

    // Non-first block straight after reset chains from zero.
    do_block(rand_blk(), 1'b0, 1'b1);
    $display("step chain_from_zero done");

    // Single-block "abc".
    do_block(abc_blk, 1'b1, 1'b1);
    chk("abc_digest", o_hash, ABC_HASH);

    // Two-block message.
    base_hv = hv_cnt;
    do_block(abcd_blk, 1'b1, 1'b0);
    chk("two_mid_no_strobe", hv_cnt, base_hv);
    do_block(pad_blk, 1'b0, 1'b1);
    chk("two_digest", o_hash, TWO_HASH);

    // Back-to-back "abc" restarts from IV.
    do_block(abc_blk, 1'b1, 1'b1);
    chk("abc_again_digest", o_hash, ABC_HASH);

    // Spurious done while idle must not disturb the chain or strobe.
    base_hv = hv_cnt;
    inj_vout = {8{$urandom}}; inj_done = 1'b1;
    tick();
    inj_done = 1'b0;
    tick();
    chk("idle_done_no_strobe", hv_cnt, base_hv);
    do_block(rand_blk(), 1'b0, 1'b1);

    // Reset 20 cycles into WAIT abandons the block.
    send(abc_blk, 1'b1, 1'b1);
    repeat (21) tick();
    base_hv = hv_cnt; base_err = err_cnt;
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    chk("midrst_ready", o_ready, 1);
    chk("midrst_hash", o_hash, 0);
    chk("midrst_vin", o_core_vin, 0);
    repeat (100) tick();
    chk("midrst_no_strobe", hv_cnt, base_hv);
    chk("midrst_no_err", err_cnt, base_err);
    model_chain = '0; model_hash = '0;
    do_block(abc_blk, 1'b1, 1'b1);
    chk("midrst_abc_digest", o_hash, ABC_HASH);

    // Randomised multi-block messages.
    for (int m = 0; m < 4; m++) begin
      int nb;
      nb = $urandom_range(1, 3);
      for (int k = 0; k < nb; k++)
        do_block(rand_blk(), (k == 0), (k == nb - 1));
    end

    // Valid held high with spurious done injected in IDLE/START.
    base_acc = acc_cnt; base_hv = hv_cnt; base_done = done_cnt;
    i_valid = 1'b1; i_data = abc_blk; i_first = 1'b1; i_last = 1'b1;
    inj_vout = {8{$urandom}};
    n = 0;
    while (n < 400) begin
      inj_done = o_ready || o_core_start;
      tick(); n++;
      if (acc_cnt - base_acc >= 3 && o_core_start) i_valid = 1'b0;
      if (!i_valid && o_ready) break;
    end
    inj_done = 1'b0;
    tick();
    chk("hold_accepts", acc_cnt - base_acc, 3);
    chk("hold_completions", done_cnt - base_done, 3);
    chk("hold_strobes", hv_cnt - base_hv, 3);
    chk("hold_digest", o_hash, ABC_HASH);
    model_chain = sm3_cf(IV, abc_blk); model_hash = model_chain;
    $display("hold_valid accepts=%0d strobes=%0d hash=%h", acc_cnt - base_acc, hv_cnt - base_hv, o_hash);

    // Core done on the last cycle before any watchdog would fire.
    base_err = err_cnt;
    stub_lat = 79;
    do_block(abc_blk, 1'b1, 1'b1);
    chk("late_done_no_err", err_cnt, base_err);
    stub_lat = 64;

`ifdef SM3_CTRL_WDT_EN
    // Dead core: error strobe 81 cycles after the start pulse, chain untouched.
    stub_dead = 1'b1;
    base_hv = hv_cnt; base_err = err_cnt;
    send(rand_blk(), 1'b0, 1'b1);
    chk("wdt_start", o_core_start, 1);
    n = 0;
    while (n < 200) begin
      tick(); n++;
      if (o_err) break;
    end
    chk("wdt_err_lat", n, 81);
    chk("wdt_ready", o_ready, 1);
    tick();
    chk("wdt_err_one_cycle", o_err, 0);
    chk("wdt_err_count", err_cnt - base_err, 1);
    chk("wdt_no_strobe", hv_cnt, base_hv);
    stub_dead = 1'b0;
    $display("watchdog err_after=%0d", n);
    do_block(rand_blk(), 1'b0, 1'b1);
`else
    chk("no_wdt_err", err_cnt, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
